// File: rtl/led_fx_pkg.sv
// led_fx_pkg: shared types and constants for the LED effect engine.
// Holds the effect-mode encoding, the PIO word field layout, the
// speed-to-period mapping and the control FSM state type.
package led_fx_pkg;

  // PIO word layout: [7:0] pattern, [10:8] mode, [12:11] speed
  localparam int WORD_W   = 13;
  localparam int PAT_LSB  = 0;
  localparam int PAT_W    = 8;
  localparam int MODE_LSB = 8;
  localparam int MODE_W   = 3;
  localparam int SPD_LSB  = 11;
  localparam int SPD_W    = 2;

  // Step period compare width (largest period is 64 ticks)
  localparam int PERIOD_W = 7;
  // PWM duty compare width (duty reaches 256 at full brightness)
  localparam int DUTY_W   = 9;

  // Phase / direction encodings
  localparam logic PHASE_ON  = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [MODE_W-1:0] {
    MODE_STATIC = 3'd0,
    MODE_BLINK  = 3'd1,
    MODE_ROT_L  = 3'd2,
    MODE_ROT_R  = 3'd3,
    MODE_BOUNCE = 3'd4,
    MODE_PWM    = 3'd5,
    MODE_RSVD6  = 3'd6,
    MODE_RSVD7  = 3'd7
  } fx_mode_e;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } fx_state_e;

  // Number of base ticks per effect step: 8, 16, 32 or 64
  function automatic logic [PERIOD_W-1:0] speed_period(input logic [SPD_W-1:0] speed);
    return 7'd8 << speed;
  endfunction

endpackage

// File: rtl/led_fx_tick_gen.sv
// led_fx_tick_gen: base-tick prescaler plus step counter.
// tick is high for the last clock of each DIV-cycle prescaler period;
// step is high on the tick that completes period(speed) ticks.
// clear zeroes both counters so a freshly loaded effect starts a full
// step period from the moment it is loaded.
module led_fx_tick_gen
  import led_fx_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [SPD_W-1:0] speed,
  output logic             tick,
  output logic             step
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0]       pre_cnt;
  logic [PERIOD_W-1:0] step_cnt;
  logic [PERIOD_W-1:0] period_last;

  assign period_last = speed_period(speed) - 7'd1;
  assign tick        = (pre_cnt == PRE_LAST);
  // >= keeps the counter from running away should speed ever shrink mid-count
  assign step        = tick && (step_cnt >= period_last);

  // Prescaler wraps at DIV-1; step counter advances per tick and wraps on step
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      if (tick) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
      if (step) begin
        step_cnt <= '0;
      end else if (tick) begin
        step_cnt <= step_cnt + 7'd1;
      end
    end
  end

endmodule

// File: rtl/led_fx_driver.sv
// led_fx_driver: LED effect engine fed by the 13-bit LED PIO word.
// Modes: static, blink, rotate left/right, bounce and (optionally) PWM dim.
// Optional feature macro: LED_FX_PWM_EN -- when defined, mode 5 is a
// PWM dimmer driven by a free-running 8-bit counter; when undefined,
// mode 5 behaves as static and the counter is not built.
// Any change of the PIO word reloads the effect; led_out is registered.
module led_fx_driver
  import led_fx_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BASE_TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] led_word,
  output logic [7:0]  led_out,
  output logic        step_pulse
);

  localparam int DIV = CLK_HZ / BASE_TICK_HZ;

  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_q2;
  logic              change;

  logic [PAT_W-1:0]  pattern;
  fx_mode_e          mode;
  logic [SPD_W-1:0]  speed;

  fx_state_e         state;
  fx_state_e         state_nxt;
  logic              clear;

  logic              tick;
  logic              step;
  logic              step_en;

  logic [7:0]        work_reg;
  logic [7:0]        work_nxt;
  logic              phase;
  logic              phase_nxt;
  logic              dir;
  logic              dir_nxt;
  logic [7:0]        led_nxt;
  logic              pulse_nxt;

  assign pattern = word_q[PAT_LSB +: PAT_W];
  assign mode    = fx_mode_e'(word_q[MODE_LSB +: MODE_W]);
  assign speed   = word_q[SPD_LSB +: SPD_W];
  assign change  = (word_q != word_q2);

  // A step only acts while running and never on the cycle a reload is flagged
  assign step_en = tick && step && (state == ST_RUN) && !change;

  led_fx_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .speed (speed),
    .tick  (tick),
    .step  (step)
  );

`ifdef LED_FX_PWM_EN
  logic [7:0]        pwm_cnt;
  logic [DUTY_W-1:0] duty;
  logic              pwm_on;

  // duty = (speed+1)*64 of a 256-cycle frame; speed 3 gives 256, i.e. always on
  assign duty   = ({{(DUTY_W-SPD_W){1'b0}}, speed} + 9'd1) << 6;
  assign pwm_on = ({1'b0, pwm_cnt} < duty);

  // Free-running PWM frame counter, wraps 255 -> 0
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end
`endif

  // Control FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Control FSM: LOAD lasts one cycle, RUN falls back to LOAD on any word change
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    case (state)
      ST_LOAD: begin
        clear     = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (change) begin
          state_nxt = ST_LOAD;
        end
      end
      default: begin
        state_nxt = ST_LOAD;
      end
    endcase
  end

  // Effect state update: reload in LOAD, otherwise advance on each step
  always_comb begin
    work_nxt  = work_reg;
    phase_nxt = phase;
    dir_nxt   = dir;
    pulse_nxt = 1'b0;
    if (state == ST_LOAD) begin
      work_nxt  = pattern;
      phase_nxt = PHASE_ON;
      dir_nxt   = DIR_LEFT;
    end else if (step_en) begin
      pulse_nxt = 1'b1;
      case (mode)
        MODE_BLINK: begin
          phase_nxt = ~phase;
        end
        MODE_ROT_L: begin
          work_nxt = {work_reg[6:0], work_reg[7]};
        end
        MODE_ROT_R: begin
          work_nxt = {work_reg[0], work_reg[7:1]};
        end
        MODE_BOUNCE: begin
          // Bits shifted off the end are lost; direction turns at the edge bit
          if (dir == DIR_LEFT) begin
            work_nxt = {work_reg[6:0], 1'b0};
            if (work_nxt[7]) begin
              dir_nxt = DIR_RIGHT;
            end
          end else begin
            work_nxt = {1'b0, work_reg[7:1]};
            if (work_nxt[0]) begin
              dir_nxt = DIR_LEFT;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // LED output selection from the next effect state; held while a reload is pending
  always_comb begin
    led_nxt = led_out;
    if (!((state == ST_RUN) && change)) begin
      case (mode)
        MODE_BLINK: begin
          led_nxt = (phase_nxt == PHASE_ON) ? pattern : 8'h00;
        end
        MODE_ROT_L, MODE_ROT_R, MODE_BOUNCE: begin
          led_nxt = work_nxt;
        end
`ifdef LED_FX_PWM_EN
        MODE_PWM: begin
          led_nxt = pwm_on ? pattern : 8'h00;
        end
`endif
        default: begin
          led_nxt = pattern;
        end
      endcase
    end
  end

  // Input sampling, effect state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q     <= '0;
      word_q2    <= '0;
      work_reg   <= '0;
      phase      <= PHASE_ON;
      dir        <= DIR_LEFT;
      led_out    <= '0;
      step_pulse <= 1'b0;
    end else begin
      word_q     <= led_word;
      word_q2    <= word_q;
      work_reg   <= work_nxt;
      phase      <= phase_nxt;
      dir        <= dir_nxt;
      led_out    <= led_nxt;
      step_pulse <= pulse_nxt;
    end
  end

endmodule
